// File: rtl/grover_measure.sv
// Collapses a vector of signed Grover amplitudes into one index, drawn with probability
// proportional to amplitude^2, and reports the most probable index alongside it.
module grover_measure #(
    parameter int unsigned num_bit        = 3,
    parameter int unsigned fixedpoint_bit = 8,
    parameter int unsigned num_sample     = 2 ** num_bit,
    parameter logic [15:0] lfsr_seed      = 16'hACE1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [num_bit-1:0]        target_search,
    input  logic [fixedpoint_bit-1:0] i0,
    input  logic [fixedpoint_bit-1:0] i1,
    input  logic [fixedpoint_bit-1:0] i2,
    input  logic [fixedpoint_bit-1:0] i3,
    input  logic [fixedpoint_bit-1:0] i4,
    input  logic [fixedpoint_bit-1:0] i5,
    input  logic [fixedpoint_bit-1:0] i6,
    input  logic [fixedpoint_bit-1:0] i7,
    output logic [num_bit-1:0]        measured,
    output logic [num_bit-1:0]        argmax,
    output logic                      hit,
    output logic                      zero_total,
    output logic                      busy,
    output logic                      valid
);

    localparam int unsigned n_port = 8;
    localparam int unsigned sw     = 2 * fixedpoint_bit;
    localparam int unsigned pw     = sw - 1;
    localparam int unsigned tw     = pw + num_bit;
    localparam int unsigned lw     = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SQUARE = 3'd1,
        DRAW   = 3'd2,
        SCAN   = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t state;
    state_t next_state;

    logic signed [fixedpoint_bit-1:0] amp [n_port];
    logic [pw-1:0]                    prob [n_port];
    logic [num_bit-1:0]               target_q;
    logic [num_bit-1:0]               cnt;
    logic [tw-1:0]                    total;
    logic [pw-1:0]                    best;
    logic [num_bit-1:0]               arg_work;
    logic [tw-1:0]                    r;
    logic [tw-1:0]                    cum;
    logic                             found;
    logic [num_bit-1:0]               meas_work;
    logic [lw-1:0]                    lfsr;

    logic                      last_c;
    logic                      load_c;
    logic                      sq_en_c;
    logic                      draw_c;
    logic                      scan_en_c;
    logic                      finish_c;
    logic                      busy_c;
    logic                      valid_c;
    logic signed [sw-1:0]      amp_ext_c;
    logic signed [sw-1:0]      sq_c;
    logic [pw-1:0]             p_c;
    logic [lw+tw-1:0]          prod_c;
    logic [tw-1:0]             r_c;
    logic [lw-1:0]             lfsr_next_c;
    logic [tw-1:0]             cum_next_c;
    logic                      scan_match_c;
    logic [num_bit-1:0]        meas_final_c;

    assign last_c = (cnt == num_bit'(num_sample - 1));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = SQUARE;
            SQUARE:  if (last_c) next_state = DRAW;
            DRAW:    next_state = SCAN;
            SCAN:    if (last_c) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Per-state datapath strobes and next values of the status flags
    always_comb begin
        load_c    = 1'b0;
        sq_en_c   = 1'b0;
        draw_c    = 1'b0;
        scan_en_c = 1'b0;
        finish_c  = 1'b0;
        busy_c    = (next_state != IDLE);
        valid_c   = (next_state == DONE);
        case (state)
            IDLE:   load_c    = start;
            SQUARE: sq_en_c   = 1'b1;
            DRAW:   draw_c    = 1'b1;
            SCAN: begin
                scan_en_c = 1'b1;
                finish_c  = last_c;
            end
            default: ;
        endcase
    end

    // Squared amplitude; a signed square never needs the sign bit
    assign amp_ext_c = sw'(amp[cnt]);
    assign sq_c      = amp_ext_c * amp_ext_c;
    assign p_c       = pw'(sq_c);

    // Random threshold scaled into [0, total)
    assign prod_c      = (lw + tw)'(lfsr) * (lw + tw)'(total);
    assign r_c         = tw'(prod_c >> lw);
    assign lfsr_next_c = {lfsr[lw-2:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

    // First index whose running sum passes the threshold wins
    assign cum_next_c   = cum + tw'(prob[cnt]);
    assign scan_match_c = !found && (cum_next_c > r);
    assign meas_final_c = scan_match_c ? cnt : meas_work;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy  <= 1'b0;
            valid <= 1'b0;
        end else begin
            busy  <= busy_c;
            valid <= valid_c;
        end
    end

    // Sample counter shared by SQUARE and SCAN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load_c) begin
            cnt <= '0;
        end else if (sq_en_c || scan_en_c) begin
            cnt <= last_c ? '0 : cnt + num_bit'(1);
        end
    end

    // Latched request and SQUARE accumulation
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < int'(n_port); k++) begin
                amp[k]  <= '0;
                prob[k] <= '0;
            end
            target_q <= '0;
            total    <= '0;
            best     <= '0;
            arg_work <= '0;
        end else if (load_c) begin
            amp[0]   <= i0;
            amp[1]   <= i1;
            amp[2]   <= i2;
            amp[3]   <= i3;
            amp[4]   <= i4;
            amp[5]   <= i5;
            amp[6]   <= i6;
            amp[7]   <= i7;
            target_q <= target_search;
            total    <= '0;
            best     <= '0;
            arg_work <= '0;
        end else if (sq_en_c) begin
            prob[cnt] <= p_c;
            total     <= total + tw'(p_c);
            if (p_c > best) begin
                best     <= p_c;
                arg_work <= cnt;
            end
        end
    end

    // Draw and scan state; the generator steps only on a draw
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr      <= lfsr_seed;
            r         <= '0;
            cum       <= '0;
            found     <= 1'b0;
            meas_work <= '0;
        end else if (load_c) begin
            cum       <= '0;
            found     <= 1'b0;
            meas_work <= '0;
        end else if (draw_c) begin
            r    <= r_c;
            lfsr <= lfsr_next_c;
        end else if (scan_en_c) begin
            cum <= cum_next_c;
            if (scan_match_c) begin
                found     <= 1'b1;
                meas_work <= cnt;
            end
        end
    end

    // Results update together on entry to DONE and hold until the next one
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            measured   <= '0;
            argmax     <= '0;
            hit        <= 1'b0;
            zero_total <= 1'b0;
        end else if (finish_c) begin
            measured   <= meas_final_c;
            argmax     <= arg_work;
            hit        <= (meas_final_c == target_q);
            zero_total <= (total == '0);
        end
    end

endmodule

// File: tb/tb_grover_measure.sv
// Self-checking bench for grover_measure: directed cases plus random amplitude vectors
// compared against a probability-sum reference model.
module tb_grover_measure;

    localparam logic [15:0] seed = 16'hACE1;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] target_search;
    logic [7:0] amp_drv [8];
    logic [2:0] measured;
    logic [2:0] argmax;
    logic       hit;
    logic       zero_total;
    logic       busy;
    logic       valid;

    int          errors = 0;
    int          checks = 0;
    int          m_amp [8];
    int          m_tgt;
    logic [15:0] m_lfsr;
    int          e_meas;
    int          e_arg;
    bit          e_hit;
    bit          e_zero;

    always #5 clk = ~clk;

    grover_measure dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .target_search (target_search),
        .i0            (amp_drv[0]),
        .i1            (amp_drv[1]),
        .i2            (amp_drv[2]),
        .i3            (amp_drv[3]),
        .i4            (amp_drv[4]),
        .i5            (amp_drv[5]),
        .i6            (amp_drv[6]),
        .i7            (amp_drv[7]),
        .measured      (measured),
        .argmax        (argmax),
        .hit           (hit),
        .zero_total    (zero_total),
        .busy          (busy),
        .valid         (valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: probabilities are squares, threshold = lfsr*total/65536, pick first
    // index whose cumulative probability exceeds it.
    task automatic model();
        int  p [8];
        int  total;
        int  best;
        int  thr;
        int  cum;
        bit  got;
        total = 0;
        for (int k = 0; k < 8; k++) begin
            p[k]  = m_amp[k] * m_amp[k];
            total += p[k];
        end
        e_arg = 0;
        best  = p[0];
        for (int k = 1; k < 8; k++) begin
            if (p[k] > best) begin
                best  = p[k];
                e_arg = k;
            end
        end
        thr    = int'((longint'(m_lfsr) * longint'(total)) >> 16);
        e_meas = 0;
        cum    = 0;
        got    = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cum += p[k];
            if (!got && total != 0 && cum > thr) begin
                e_meas = k;
                got    = 1'b1;
            end
        end
        e_hit  = (e_meas == m_tgt);
        e_zero = (total == 0);
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    endtask

    task automatic set_amps(input int a0, input int a1, input int a2, input int a3,
                            input int a4, input int a5, input int a6, input int a7,
                            input int tgt);
        m_amp[0] = a0; m_amp[1] = a1; m_amp[2] = a2; m_amp[3] = a3;
        m_amp[4] = a4; m_amp[5] = a5; m_amp[6] = a6; m_amp[7] = a7;
        m_tgt    = tgt;
    endtask

    // One full measurement; inputs are scrambled once the request is latched.
    task automatic run(input string tag, input int busy_at);
        int pulses;
        @(negedge clk);
        for (int k = 0; k < 8; k++) amp_drv[k] = 8'(m_amp[k]);
        target_search = 3'(m_tgt);
        start         = 1'b1;
        model();
        pulses = 0;
        for (int cyc = 1; cyc <= 24; cyc++) begin
            @(negedge clk);
            start = (cyc == busy_at);
            for (int k = 0; k < 8; k++) amp_drv[k] = 8'($urandom);
            target_search = 3'($urandom);
            if (valid) pulses++;
            if (cyc == 1)  check({tag, "/busy1"}, 32'(busy), 32'd1);
            if (cyc == 17) check({tag, "/valid17"}, 32'(valid), 32'd0);
            if (cyc == 18) begin
                check({tag, "/valid18"}, 32'(valid), 32'd1);
                check({tag, "/measured"}, 32'(measured), 32'(e_meas));
                check({tag, "/argmax"}, 32'(argmax), 32'(e_arg));
                check({tag, "/hit"}, 32'(hit), 32'(e_hit));
                check({tag, "/zero_total"}, 32'(zero_total), 32'(e_zero));
            end
            if (cyc == 19) check({tag, "/busy19"}, 32'(busy), 32'd0);
            if (cyc == 24) check({tag, "/measured_held"}, 32'(measured), 32'(e_meas));
        end
        start = 1'b0;
        check({tag, "/pulses"}, 32'(pulses), 32'd1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "/measured"}, 32'(measured), 32'd0);
        check({tag, "/argmax"}, 32'(argmax), 32'd0);
        check({tag, "/hit"}, 32'(hit), 32'd0);
        check({tag, "/zero_total"}, 32'(zero_total), 32'd0);
        check({tag, "/busy"}, 32'(busy), 32'd0);
        check({tag, "/valid"}, 32'(valid), 32'd0);
    endtask

    initial begin
        int pulses;
        rst           = 1'b0;
        start         = 1'b0;
        target_search = '0;
        for (int k = 0; k < 8; k++) amp_drv[k] = '0;
        m_lfsr = seed;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst = 1'b1;

        // Uniform amplitudes on the first draw after reset
        set_amps(22, 22, 22, 22, 22, 22, 22, 22, 2);
        run("uniform", 0);
        check("uniform/fixed_measured", 32'(measured), 32'd5);
        check("uniform/fixed_argmax", 32'(argmax), 32'd0);
        check("uniform/fixed_hit", 32'(hit), 32'd0);

        set_amps(0, 0, 0, 0, 0, 64, 0, 0, 5);
        run("peak", 0);
        check("peak/fixed_measured", 32'(measured), 32'd5);
        check("peak/fixed_hit", 32'(hit), 32'd1);

        set_amps(0, 0, 0, -128, 0, 0, 0, 0, 3);
        run("neg", 0);
        check("neg/fixed_measured", 32'(measured), 32'd3);
        check("neg/fixed_argmax", 32'(argmax), 32'd3);

        set_amps(0, 0, 0, 0, 0, 0, 0, 0, 4);
        run("zero", 0);
        check("zero/fixed_zero_total", 32'(zero_total), 32'd1);
        check("zero/fixed_hit", 32'(hit), 32'd0);

        // Ties on the max and a second start while busy
        set_amps(10, -90, 3, 90, 0, -7, 50, 90, 6);
        run("busy_start", 5);

        for (int t = 0; t < 20; t++) begin
            for (int k = 0; k < 8; k++) begin
                if ((t % 3) == 0 && ($urandom % 2) == 0) m_amp[k] = 0;
                else m_amp[k] = int'($urandom_range(255, 0)) - 128;
            end
            m_tgt = int'($urandom_range(7, 0));
            run($sformatf("rand%0d", t), (t % 4 == 1) ? int'($urandom_range(16, 2)) : 0);
        end

        // Abort in the middle of SCAN
        set_amps(22, 22, 22, 22, 22, 22, 22, 22, 5);
        @(negedge clk);
        for (int k = 0; k < 8; k++) amp_drv[k] = 8'(m_amp[k]);
        target_search = 3'(m_tgt);
        start         = 1'b1;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == 12) rst = 1'b0;
        end
        #1;
        check_zero_outputs("abort");
        repeat (2) @(negedge clk);
        rst    = 1'b1;
        m_lfsr = seed;
        pulses = 0;
        for (int cyc = 0; cyc < 25; cyc++) begin
            @(negedge clk);
            if (valid) pulses++;
        end
        check("abort/pulses", 32'(pulses), 32'd0);

        set_amps(22, 22, 22, 22, 22, 22, 22, 22, 2);
        run("uniform_again", 0);
        check("uniform_again/fixed_measured", 32'(measured), 32'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/grover_measure.md
GROVER_MEASURE -- requirements
Module: grover_measure

Interface
REQ-001 SHALL have parameter num_bit, default 3, meaning the index width.
REQ-002 SHALL have parameter fixedpoint_bit, default 8, meaning the signed amplitude width.
REQ-003 SHALL have parameter num_sample, default 2**num_bit (8), meaning the number of amplitudes.
REQ-004 SHALL have parameter lfsr_seed, default 16'hACE1, meaning the random generator reset value.
REQ-005 SHALL provide one clock and reset, asynchronous and active-low: clk in 1, system clock, rising edge; rst in 1, asynchronous active-low reset.
REQ-006 SHALL have start  in  1  measure request, typically driven by the search core's done.
REQ-007 SHALL have target_search  in  num_bit  expected index.
REQ-008 SHALL have i0..i7  in  fixedpoint_bit each  signed amplitudes, index 0..7.
REQ-009 SHALL have measured  out  num_bit  randomly collapsed index.
REQ-010 SHALL have argmax  out  num_bit  index of the largest squared amplitude.
REQ-011 SHALL have hit  out  1  measured == target_search, sampled at start.
REQ-012 SHALL have zero_total  out  1  all amplitudes were zero.
REQ-013 SHALL have busy  out  1  measurement in progress.
REQ-014 SHALL have valid  out  1  one-cycle result strobe.

Function
REQ-015 SHALL implement the FSM IDLE -> SQUARE -> DRAW -> SCAN -> DONE -> IDLE.
REQ-016 In IDLE with start=1 at a rising edge, SHALL latch i0..i7 and target_search, then enter SQUARE; busy=1 in every state except IDLE.
REQ-017 SHALL ignore start while busy=1; the latched inputs stay unchanged.
REQ-018 SQUARE: 8 cycles, one sample k per cycle; p[k]=amp[k]*amp[k], unsigned 2*fixedpoint_bit-1 bits (15); total accumulates in 18 bits without overflow, so (-128)^2=16384 is exact.
REQ-019 SQUARE: argmax SHALL update only when p[k] > best; ties keep the lower index.
REQ-020 DRAW: 1 cycle; r=(lfsr*total)>>16, truncated to 18 bits.
REQ-021 DRAW: the LFSR SHALL then advance one step using the 16-bit Fibonacci polynomial x^16+x^14+x^13+x^11+1, shifting left with feedback into bit 0.
REQ-022 SCAN: always exactly 8 cycles; running cumulative sum cum_k=p[0]+..+p[k]; measured is the first k with cum_k > r, and later matches SHALL NOT overwrite it.
REQ-023 If total==0, SHALL give measured=0, argmax=0, zero_total=1.
REQ-024 DONE: 1 cycle; valid=1 for exactly that cycle; hit and zero_total update at the same time.
REQ-025 Latency SHALL be fixed: valid high in the 18th cycle after the start-sampling edge (8 SQUARE + 1 DRAW + 8 SCAN + DONE).
REQ-026 measured, argmax, hit and zero_total SHALL hold their values until the next DONE.
REQ-027 The LFSR SHALL advance only in DRAW, never in any other state.

Reset
REQ-028 While rst=0: state IDLE; measured, argmax, hit, zero_total, busy and valid all 0.
REQ-029 While rst=0: lfsr=lfsr_seed; all accumulators and latched samples 0.
REQ-030 Reset asserted mid-operation SHALL abort immediately; no valid pulse for that request.
REQ-031 The first start after reset release SHALL be accepted normally.

Verification
REQ-032 Single peak: i5=64, others 0, target 5, start -> valid at cycle 18; measured=5, argmax=5, hit=1, zero_total=0.
REQ-033 Uniform: all amplitudes 22 (total 3872), first draw after reset, lfsr=16'hACE1, target 2 -> r=2614; measured=5, argmax=0, hit=0.
REQ-034 Negative amplitude: i3=-128, others 0, target 3 -> measured=3, argmax=3, hit=1; internal p[3]=16384.
REQ-035 All zero: amplitudes 0, target 4 -> measured=0, argmax=0, zero_total=1, hit=0.
REQ-036 Start while busy: second start pulse at cycle 5 -> ignored; exactly one valid pulse at cycle 18.
REQ-037 Reset mid-SCAN: rst=0 at cycle 12 -> no valid pulse, all outputs 0, lfsr back to 16'hACE1; repeating the uniform case SHALL give measured=5 again.
